read_data_register: RTL

//  Captures DRAM read-burst data from the DQ bus on the controller's return path.
//  - Waits a fixed CAS latency after the controller issues a READ.
//  - Samples BURST_LEN beats and assembles them into one wide word.
//  - Presents the word to the host side with a valid/ready handshake.

---
 rtl/read_data_register_if.sv | 28 ++
 rtl/read_data_register.sv | 112 +++++++++++
 2 files changed

// File: rtl/read_data_register_if.sv
// Read-return bus of the DRAM controller.
// Groups the issue strobe, the DQ beat input, the host valid/ready handshake
// and the sticky error flags. The capture block connects through the slave
// modport. The controller/host side connects through the master modport.
interface read_data_register_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8
);
  logic                            rd_issue;
  logic                            rd_accept;
  logic [DATA_WIDTH-1:0]           dq_in;
  logic [DATA_WIDTH*BURST_LEN-1:0] rdata;
  logic                            rdata_valid;
  logic                            rdata_ready;
  logic                            overrun;
  logic                            issue_err;
  logic                            clear_err;

  modport master (
    output rd_issue, dq_in, rdata_ready, clear_err,
    input  rd_accept, rdata, rdata_valid, overrun, issue_err
  );

  modport slave (
    input  rd_issue, dq_in, rdata_ready, clear_err,
    output rd_accept, rdata, rdata_valid, overrun, issue_err
  );
endinterface

// File: rtl/read_data_register.sv
// DRAM read-return capture.
// After a READ is issued, the block waits CL cycles. It then samples
// BURST_LEN DQ beats and hands the assembled word to the host through
// valid/ready. DRAM cannot be stalled. If a burst completes while the
// previous word is still pending, the new burst is dropped and overrun is flagged.
module read_data_register #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CL         = 5
) (
  input logic                 clk,
  input logic                 rst,
  read_data_register_if.slave bus
);
  localparam int WORD_W = DATA_WIDTH * BURST_LEN;
  localparam int WCNT_W = $clog2(CL + 1);
  localparam int BCNT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_W-1:0]   beats_q, beats_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                ierr_q, ierr_d;
  logic                burst_done;
  logic                load;
  logic [WORD_W-1:0]   full_word;

  // Sequence the READ: latency countdown, then beat capture into slots.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    beats_d    = beats_q;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_issue) begin
          bcnt_d = '0;
          if (CL == 1) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(CL - 1);
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = CAPTURE;
          bcnt_d  = '0;
        end
      end
      CAPTURE: begin
        beats_d[int'(bcnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.dq_in;
        bcnt_d = bcnt_q + BCNT_W'(1);
        if (bcnt_q == BCNT_W'(BURST_LEN - 1)) begin
          state_d    = IDLE;
          burst_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake and sticky flags. The final beat bypasses the slot register.
  always_comb begin
    full_word = beats_q;
    full_word[(BURST_LEN-1)*DATA_WIDTH +: DATA_WIDTH] = bus.dq_in;
    load      = burst_done & (~valid_q | bus.rdata_ready);
    rdata_d   = load ? full_word : rdata_q;
    valid_d   = load | (valid_q & ~bus.rdata_ready);
    overrun_d = (overrun_q & ~bus.clear_err) |
                (burst_done & valid_q & ~bus.rdata_ready);
    ierr_d    = (ierr_q & ~bus.clear_err) |
                (bus.rd_issue & (state_q != IDLE));
  end

  // State, counters, beat slots and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      beats_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ierr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      beats_q   <= beats_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ierr_q    <= ierr_d;
    end
  end

  assign bus.rd_accept   = (state_q == IDLE);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.issue_err   = ierr_q;
endmodule
